// File: rtl/display_pkg.sv
// display_pkg: segment constants, nibble decode and scan-timing helpers for the display mux
package display_pkg;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_TABLE [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                             SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble, input logic hex_mode);
    return (!hex_mode && nibble > 4'd9) ? SEG_DASH : SEG_TABLE[nibble];
  endfunction
  function automatic int sub_max(input int refresh, input int bright_w);
    return (refresh >> bright_w) - 1;
  endfunction
  function automatic int phase_max(input int bright_w);
    return (1 << bright_w) - 1;
  endfunction
endpackage

// File: rtl/module_seg_decoder.sv
// module_seg_decoder: nibble to active-high {g..a} segments, hex or decimal-with-dash
module module_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);
  assign seg = seg_decode(nibble, hex_mode);
endmodule

// File: rtl/module_display_mux_n.sv
// module_display_mux_n: double-buffered N-digit multiplexed 7-segment driver with PWM brightness
module module_display_mux_n
  import display_pkg::*;
#(
  parameter int N_DIGITS        = 4,
  parameter int DISPLAY_REFRESH = 27000,
  parameter int BRIGHT_W        = 3,
  parameter bit ANODE_ACT_LOW   = 1'b1,
  parameter bit SEG_ACT_LOW     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic                  hex_mode_i,
  input  logic                  blank_lz_i,
  input  logic [BRIGHT_W-1:0]   brightness_i,
  output logic [N_DIGITS-1:0]   anodo_o,
  output logic [6:0]            catodo_o,
  output logic                  dp_o
);
  localparam int SW = $clog2((DISPLAY_REFRESH >> BRIGHT_W) + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [SW-1:0] SUB_MAX = SW'(sub_max(DISPLAY_REFRESH, BRIGHT_W));
  localparam logic [BRIGHT_W-1:0] PHASE_MAX = BRIGHT_W'(phase_max(BRIGHT_W));
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  logic [SW-1:0] sub_cnt;
  logic [BRIGHT_W-1:0] phase, bright;
  logic [IW-1:0] idx;
  logic [4*N_DIGITS-1:0] shadow_val, active_val;
  logic [N_DIGITS-1:0] shadow_dp, active_dp, onehot;
  logic sub_end, slot_end, blank, lit;
  logic [3:0] nib;
  logic [6:0] seg_raw, seg;
  assign sub_end = sub_cnt == SUB_MAX;
  assign slot_end = sub_end && phase == PHASE_MAX;
  assign nib = active_val[{idx, 2'b00} +: 4];
  assign blank = blank_lz_i && idx != '0 && (active_val >> {idx, 2'b00}) == '0;
  assign seg = blank ? SEG_BLANK : seg_raw;
  assign onehot = N_DIGITS'(1) << idx;
  assign lit = phase <= bright;
  module_seg_decoder u_dec (
    .nibble   (nib),
    .hex_mode (hex_mode_i),
    .seg      (seg_raw)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sub_cnt    <= '0;
      phase      <= '0;
      idx        <= '0;
      bright     <= '1;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      anodo_o    <= {N_DIGITS{ANODE_ACT_LOW}};
      catodo_o   <= {7{SEG_ACT_LOW}};
      dp_o       <= SEG_ACT_LOW;
    end else begin
      sub_cnt <= sub_end ? '0 : sub_cnt + 1'b1;
      if (sub_end) phase <= phase == PHASE_MAX ? '0 : phase + 1'b1;
      if (load_i) begin
        shadow_val <= value_i;
        shadow_dp  <= dp_i;
      end
      if (slot_end) begin
        idx        <= idx == IDX_MAX ? '0 : idx + 1'b1;
        bright     <= brightness_i;
        active_val <= load_i ? value_i : shadow_val;
        active_dp  <= load_i ? dp_i : shadow_dp;
      end
      anodo_o  <= (lit ? onehot : '0) ^ {N_DIGITS{ANODE_ACT_LOW}};
      catodo_o <= seg ^ {7{SEG_ACT_LOW}};
      dp_o     <= active_dp[idx] ^ SEG_ACT_LOW;
    end
  end
endmodule
